// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan receiver: segment table, FSM states, strobe helper.
package seg_pkg;

    localparam int SEG_WIDTH  = 7;
    localparam int MAX_DIGITS = 8;

    // Active-low segment codes, bit6=g .. bit0=a, indexed by the nibble they display.
    localparam logic [SEG_WIDTH-1:0] SEG_CODE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    // True when exactly one strobe is low; unused upper bits must be padded high.
    function automatic logic is_onehot_low(input logic [MAX_DIGITS-1:0] dig_n);
        int unsigned lows;
        lows = 0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (!dig_n[i]) lows++;
        end
        return (lows == 1);
    endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Purpose: map an active-low 7-segment pattern back to its hex nibble, flagging unknown codes.
// Latency: combinational.
// Backpressure: none.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [SEG_WIDTH-1:0] seg,
    output logic [3:0]           nibble,
    output logic                 invalid
);

    always_comb begin
        nibble  = 4'h0;
        invalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_CODE[i]) begin
                nibble  = 4'(i);
                invalid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Purpose: observe a multiplexed 7-segment bus and rebuild the displayed NDIGITS-digit hex value.
// Latency: SYNC_STAGES + STABLE_CYCLES from stable pins to digit capture, +1 to the valid pulse.
// Backpressure: none; free-running observer, outputs are pulses and held registers.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NDIGITS       = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SEG_WIDTH-1:0]   seg,
    input  logic [NDIGITS-1:0]     dig,
    output logic [4*NDIGITS-1:0]   value,
    output logic                   valid,
    output logic                   err,
    output logic [NDIGITS-1:0]     digit_err
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = $clog2(NDIGITS);

    logic [SEG_WIDTH-1:0]      seg_sync [SYNC_STAGES];
    logic [NDIGITS-1:0]        dig_sync [SYNC_STAGES];
    logic [SEG_WIDTH-1:0]      seg_s, seg_p;
    logic [NDIGITS-1:0]        dig_s, dig_p;
    logic [MAX_DIGITS-1:0]     dig_pad;
    logic [IW-1:0]             dig_idx;
    logic                      dig_ok, changed, cap, frame_done;
    logic [3:0]                nib;
    logic                      inv;
    logic [CW-1:0]             cnt;
    state_t                    state;
    logic [NDIGITS-1:0]        mask, mask_next;
    logic [NDIGITS-1:0][3:0]   shadow_nib;
    logic [NDIGITS-1:0]        shadow_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                seg_sync[i] <= '1;
                dig_sync[i] <= '1;
            end
        end else begin
            seg_sync[0] <= seg;
            dig_sync[0] <= dig;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                seg_sync[i] <= seg_sync[i-1];
                dig_sync[i] <= dig_sync[i-1];
            end
        end
    end

    assign seg_s = seg_sync[SYNC_STAGES-1];
    assign dig_s = dig_sync[SYNC_STAGES-1];

    seg_pattern_decode u_decode (
        .seg     (seg_s),
        .nibble  (nib),
        .invalid (inv)
    );

    always_comb begin
        dig_pad = '1;
        dig_pad[NDIGITS-1:0] = dig_s;
        dig_idx = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (!dig_s[i]) dig_idx = IW'(i);
        end
    end

    assign dig_ok     = is_onehot_low(dig_pad);
    assign changed    = (seg_s != seg_p) || (dig_s != dig_p);
    assign cap        = (state == SETTLE) && !changed && (cnt == CW'(STABLE_CYCLES));
    assign frame_done = &mask;

    // A capture landing on the frame-complete cycle seeds the next frame's mask.
    always_comb begin
        mask_next = frame_done ? '0 : mask;
        if (cap) mask_next[dig_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            seg_p      <= '1;
            dig_p      <= '1;
            mask       <= '0;
            shadow_nib <= '0;
            shadow_err <= '0;
            value      <= '0;
            valid      <= 1'b0;
            err        <= 1'b0;
            digit_err  <= '0;
        end else begin
            seg_p <= seg_s;
            dig_p <= dig_s;
            valid <= frame_done;
            err   <= cap && inv;
            mask  <= mask_next;

            if (frame_done) begin
                value     <= shadow_nib;
                digit_err <= shadow_err;
            end

            if (cap) begin
                shadow_nib[dig_idx] <= nib;
                shadow_err[dig_idx] <= inv;
            end

            case (state)
                IDLE: begin
                    if (dig_ok) begin
                        state <= SETTLE;
                        cnt   <= CW'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                SETTLE: begin
                    if (changed) begin
                        if (dig_ok) begin
                            cnt   <= CW'(1);
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end else if (cap) begin
                        state <= HOLD;
                    end else begin
                        cnt   <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    // Counter stays saturated until the bus moves.
                    if (changed) begin
                        if (dig_ok) begin
                            state <= SETTLE;
                            cnt   <= CW'(1);
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomised and directed scoreboard bench for seg_scan_decoder with a frame-level reference model.
module tb_seg_scan_decoder;

    localparam int ND    = 4;
    localparam int LONG  = 8;
    localparam int SHORT = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [6:0]      seg = 7'h7F;
    logic [ND-1:0]   dig = '1;
    logic [4*ND-1:0] value;
    logic            valid, err;
    logic [ND-1:0]   digit_err;

    seg_scan_decoder #(.NDIGITS(ND), .STABLE_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg       (seg),
        .dig       (dig),
        .value     (value),
        .valid     (valid),
        .err       (err),
        .digit_err (digit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4*ND-1:0] v;
        logic [ND-1:0]   e;
    } frame_t;

    frame_t exp_q[$];
    frame_t mon_f;
    int n_cmp = 0, n_bad = 0;
    int err_exp = 0, err_seen = 0, valid_cnt = 0;

    logic [6:0] code_tbl [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [3:0]    m_nib [ND];
    logic          m_err [ND];
    logic [ND-1:0] m_mask = '0;
    logic [ND-1:0] prev_d = '1;
    logic [6:0]    prev_s = 7'h7F;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        for (int k = 0; k < 16; k++) begin
            if (code_tbl[k] == s) return {1'b0, 4'(k)};
        end
        return 5'h10;
    endfunction

    // Frame-level model: a captured digit fills its slot; a full set publishes one frame.
    task automatic model_capture(input logic [ND-1:0] d, input logic [6:0] s);
        int idx;
        logic [4:0] r;
        frame_t f;
        idx = 0;
        for (int i = 0; i < ND; i++) if (!d[i]) idx = i;
        r = ref_decode(s);
        m_nib[idx] = r[3:0];
        m_err[idx] = r[4];
        if (r[4]) err_exp++;
        m_mask[idx] = 1'b1;
        if (&m_mask) begin
            for (int i = 0; i < ND; i++) begin
                f.v[4*i +: 4] = m_nib[i];
                f.e[i]        = m_err[i];
            end
            exp_q.push_back(f);
            m_mask = '0;
        end
    endtask

    // Holds pins for len cycles; one-hot holds of LONG or more are captures, SHORT ones never are.
    task automatic step(input logic [ND-1:0] d, input logic [6:0] s, input int len);
        if (d == prev_d && s == prev_s) begin
            dig = '1;
            repeat (SHORT) @(negedge clk);
        end
        dig = d;
        seg = s;
        prev_d = d;
        prev_s = s;
        if ($countones(~d) == 1 && len >= LONG) model_capture(d, s);
        repeat (len) @(negedge clk);
    endtask

    function automatic logic [ND-1:0] strobe(input int i);
        logic [ND-1:0] d;
        d = '1;
        d[i] = 1'b0;
        return d;
    endfunction

    task automatic drain(input string name);
        dig = '1;
        prev_d = '1;
        repeat (20) @(negedge clk);
        chk({name, "_pending_frames"}, exp_q.size(), 0);
        chk({name, "_err_pulses"}, err_seen, err_exp);
        exp_q.delete();
        err_seen = err_exp;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid === 1'b1) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 32'(valid), 0);
                end else begin
                    mon_f = exp_q.pop_front();
                    chk("frame_value", 32'(value), 32'(mon_f.v));
                    chk("frame_digit_err", 32'(digit_err), 32'(mon_f.e));
                end
            end
            if (err === 1'b1) err_seen++;
        end
    end

    initial begin
        int v0, r, idx, j;
        int order [ND];
        logic [ND-1:0] d;
        logic [6:0] code;

        repeat (2) @(negedge clk);
        chk("reset_value", 32'(value), 0);
        chk("reset_valid", 32'(valid), 0);
        chk("reset_err", 32'(err), 0);
        chk("reset_digit_err", 32'(digit_err), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Digits 1,2,3,4 on strobes 0..3.
        step(4'b1110, 7'h79, 8);
        step(4'b1101, 7'h24, 8);
        step(4'b1011, 7'h30, 8);
        step(4'b0111, 7'h19, 8);
        drain("t1");
        chk("t1_value", 32'(value), 32'h4321);
        chk("t1_digit_err", 32'(digit_err), 0);

        // All 16 codes walked through digit 0.
        v0 = valid_cnt;
        for (int k = 0; k < 16; k++) begin
            step(4'b1110, code_tbl[k], 8);
            step(4'b1101, 7'h40, 8);
            step(4'b1011, 7'h40, 8);
            step(4'b0111, 7'h40, 8);
        end
        drain("t2");
        chk("t2_frames", valid_cnt - v0, 16);
        chk("t2_last_value", 32'(value), 32'h000F);

        // Segment chatter on a held strobe must never capture digit 0.
        v0 = valid_cnt;
        for (int k = 0; k < 8; k++) begin
            step(4'b1110, 7'h79, SHORT);
            step(4'b1110, 7'h24, SHORT);
        end
        step(4'b1101, 7'h24, 8);
        step(4'b1011, 7'h30, 8);
        step(4'b0111, 7'h19, 8);
        dig = '1; prev_d = '1;
        repeat (12) @(negedge clk);
        chk("t3_no_frame", valid_cnt - v0, 0);
        step(4'b1110, 7'h12, 8);
        drain("t3");
        chk("t3_value", 32'(value), 32'h4325);

        // Dark digit 2.
        step(4'b1110, 7'h40, 8);
        step(4'b1101, 7'h79, 8);
        step(4'b1011, 7'h7F, 8);
        step(4'b0111, 7'h30, 8);
        drain("t4");
        chk("t4_value", 32'(value), 32'h3010);
        chk("t4_digit_err", 32'(digit_err), 32'b0100);

        // Blanking and multi-low strobes between digits.
        step(4'b1110, 7'h06, 8);
        step(4'b1111, 7'h06, 5);
        step(4'b1101, 7'h0E, 8);
        step(4'b1100, 7'h0E, 8);
        step(4'b1011, 7'h46, 8);
        step(4'b1111, 7'h46, 3);
        step(4'b0101, 7'h21, 8);
        step(4'b0111, 7'h21, 8);
        drain("t5");
        chk("t5_value", 32'(value), 32'hDCFE);
        chk("t5_digit_err", 32'(digit_err), 0);

        // Reset after three digits discards the partial frame.
        step(4'b1110, 7'h79, 8);
        step(4'b1101, 7'h79, 8);
        step(4'b1011, 7'h79, 8);
        rst_n = 1'b0;
        dig = '1; seg = 7'h7F; prev_d = '1; prev_s = 7'h7F;
        m_mask = '0;
        repeat (2) @(negedge clk);
        chk("t6_rst_value", 32'(value), 0);
        chk("t6_rst_valid", 32'(valid), 0);
        chk("t6_rst_err", 32'(err), 0);
        chk("t6_rst_digit_err", 32'(digit_err), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        v0 = valid_cnt;
        step(4'b1101, 7'h30, 8);
        step(4'b1011, 7'h19, 8);
        step(4'b0111, 7'h12, 8);
        dig = '1; prev_d = '1;
        repeat (12) @(negedge clk);
        chk("t6_no_frame", valid_cnt - v0, 0);
        chk("t6_value_held_zero", 32'(value), 0);
        step(4'b1110, 7'h24, 8);
        drain("t6");
        chk("t6_value", 32'(value), 32'h5432);

        // Randomised frames with idle states, glitches, bad codes and overwrites.
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < ND; i++) order[i] = i;
            for (int i = ND - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                idx = order[i]; order[i] = order[j]; order[j] = idx;
            end
            for (int i = 0; i < ND; i++) begin
                idx = order[i];
                r = $urandom_range(0, 9);
                if (r < 2) begin
                    step('1, 7'($urandom), $urandom_range(2, 6));
                end else if (r < 4) begin
                    d = strobe(idx);
                    d[(idx + 1 + $urandom_range(0, ND - 2)) % ND] = 1'b0;
                    step(d, 7'($urandom), $urandom_range(2, 9));
                end
                if ($urandom_range(0, 3) == 0) step(strobe(idx), 7'($urandom), SHORT);
                code = ($urandom_range(0, 7) == 0) ? 7'($urandom) : code_tbl[$urandom_range(0, 15)];
                step(strobe(idx), code, $urandom_range(LONG, LONG + 4));
                if ($urandom_range(0, 5) == 0) step(strobe(idx), code_tbl[$urandom_range(0, 15)], LONG);
            end
        end
        drain("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
